// File: rtl/serial_adder_sub.sv
// Multi-cycle add/subtract: a BITS_PER_CYCLE-wide ripple slice plus carry flop, LSB-first.
// Latency: start edge, then WIDTH/BITS_PER_CYCLE slice edges; done pulses the cycle after the last slice.
// Backpressure: start is accepted only while ready=1; start during BUSY/DONE is dropped, abort cancels BUSY.
module serial_adder_sub #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTEP = WIDTH / BITS_PER_CYCLE;
    localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(NSTEP - 1);

    if (WIDTH < 2 || BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > WIDTH ||
        (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
        $error("serial_adder_sub: illegal WIDTH/BITS_PER_CYCLE combination");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        state_q;
    state_t                        state_d;
    logic [WIDTH-1:0]              op_a;
    logic [WIDTH-1:0]              op_b;
    logic [WIDTH-1:0]              part;
    logic                          carry;
    logic [SW-1:0]                 step;
    logic [BITS_PER_CYCLE-1:0]     slice_sum;
    logic [BITS_PER_CYCLE:0]       chain;
    logic [WIDTH+BITS_PER_CYCLE-1:0] part_cat;
    logic [WIDTH-1:0]              part_next;
    logic                          last_step;

    // Ripple slice over the low bits of the operand shift registers; chain[i] is the carry into bit i.
    always_comb begin
        chain     = '0;
        slice_sum = '0;
        chain[0]  = carry;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            slice_sum[i] = op_a[i] ^ op_b[i] ^ chain[i];
            chain[i+1]   = (op_a[i] & op_b[i]) | (chain[i] & (op_a[i] ^ op_b[i]));
        end
    end

    // New slice enters the partial sum from the MSB side; after the last slice it is the full result.
    assign part_cat  = {slice_sum, part};
    assign part_next = WIDTH'(part_cat >> BITS_PER_CYCLE);
    assign last_step = (step == LAST_STEP);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: abort beats completion, DONE always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = BUSY;
            BUSY: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == BUSY);
    assign done  = (state_q == DONE);

    // Operand capture, per-slice shifting, and result load on the edge entering DONE.
    // Subtraction is a + ~b + ~borrow, so the carry flop starts at cin ^ sub.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            part  <= '0;
            carry <= 1'b0;
            step  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state_q == IDLE && start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= cin ^ sub;
            step  <= '0;
            part  <= '0;
        end else if (state_q == BUSY) begin
            op_a  <= op_a >> BITS_PER_CYCLE;
            op_b  <= op_b >> BITS_PER_CYCLE;
            carry <= chain[BITS_PER_CYCLE];
            step  <= step + 1'b1;
            part  <= part_next;
            if (last_step && !abort) begin
                sum  <= part_next;
                cout <= chain[BITS_PER_CYCLE];
                ovf  <= chain[BITS_PER_CYCLE] ^ chain[BITS_PER_CYCLE-1];
            end
        end
    end

endmodule
